// File: rtl/spart_fifo.sv
// SPART with TX/RX FIFOs, optional parity and sticky error flags behind an 8-bit host bus.
// Serial side is 16x oversampled off a programmable baud divisor.
module spart_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'h028B,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Host bus decode
  logic       rd_en, wr_en;
  logic [7:0] wr_data, rd_data, status;
  logic       host_push, host_ctrl, wr_div_lo, wr_div_hi, host_rd_data;

  assign rd_en        = iocs & iorw;
  assign wr_en        = iocs & ~iorw;
  assign wr_data      = databus;
  assign host_push    = wr_en && (ioaddr == 2'b00);
  assign host_ctrl    = wr_en && (ioaddr == 2'b01);
  assign wr_div_lo    = wr_en && (ioaddr == 2'b10);
  assign wr_div_hi    = wr_en && (ioaddr == 2'b11);
  assign host_rd_data = rd_en && (ioaddr == 2'b00);

  // Baud generator
  logic [15:0] divisor, baud_cnt;
  logic        tick;

  assign tick = (baud_cnt <= 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= DIV_RESET;
      baud_cnt <= DIV_RESET;
    end else if (wr_div_lo) begin
      divisor  <= {divisor[15:8], wr_data};
      baud_cnt <= {divisor[15:8], wr_data};
    end else if (wr_div_hi) begin
      divisor  <= {wr_data, divisor[7:0]};
      baud_cnt <= {wr_data, divisor[7:0]};
    end else if (tick) begin
      baud_cnt <= divisor;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [AW:0]   tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign tx_push  = host_push && !tx_full;
  assign tx_head  = tx_mem[tx_rptr];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [AW:0]   rx_count;
  logic          rx_full, rx_empty, rx_push_req, rx_push, rx_pop;
  logic [7:0]    rx_shift;

  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_push  = rx_push_req && !rx_full;
  assign rx_pop   = host_rd_data && !rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // Control and sticky flags; a new error outranks a same-edge clear
  logic parity_en, parity_odd;
  logic rx_overrun, frame_err, parity_err, tx_overflow;
  logic flag_clr, frame_set, parity_set;

  assign flag_clr = host_ctrl && wr_data[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_en   <= 1'b0;
      parity_odd  <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (host_ctrl) begin
        parity_en  <= wr_data[0];
        parity_odd <= wr_data[1];
      end
      tx_overflow <= (tx_overflow & ~flag_clr) | (host_push & tx_full);
      rx_overrun  <= (rx_overrun  & ~flag_clr) | (rx_push_req & rx_full);
      frame_err   <= (frame_err   & ~flag_clr) | frame_set;
      parity_err  <= (parity_err  & ~flag_clr) | parity_set;
    end
  end

  // TX state machine
  state_t     tx_state;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bitn;
  logic [7:0] tx_shift;
  logic       tx_par, tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == LAST_TICK);
  // Reloading straight out of STOP keeps back-to-back frames gapless
  assign tx_pop = !tx_empty &&
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      txd      <= 1'b1;
      tx_tcnt  <= '0;
      tx_bitn  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= S_START;
      txd      <= 1'b0;
      tx_tcnt  <= '0;
      tx_shift <= tx_head;
      tx_par   <= ^tx_head ^ parity_odd;
    end else if ((tx_state != S_IDLE) && tick) begin
      tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
      if (tx_bit_end) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bitn  <= '0;
            txd      <= tx_shift[0];
          end
          S_DATA: begin
            if (tx_bitn == 3'd7) begin
              tx_state <= parity_en ? S_PARITY : S_STOP;
              txd      <= parity_en ? tx_par : 1'b1;
            end else begin
              tx_bitn  <= tx_bitn + 1'b1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP;
            txd      <= 1'b1;
          end
          S_STOP: begin
            tx_state <= S_IDLE;
            txd      <= 1'b1;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // RX synchronizer and state machine
  state_t     rx_state;
  logic       rx_s1, rx_s2, rx_prev, rx_perr;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bitn;
  logic       rx_mid, rx_samp;

  assign rx_mid      = tick && (rx_tcnt == MID_TICK);
  assign rx_samp     = tick && (rx_tcnt == LAST_TICK);
  assign rx_push_req = (rx_state == S_STOP) && rx_samp && rx_s2;
  assign frame_set   = (rx_state == S_STOP) && rx_samp && !rx_s2;
  assign parity_set  = rx_push_req && rx_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= S_START;
            rx_tcnt  <= '0;
            rx_perr  <= 1'b0;
          end
        end
        S_START: begin
          if (rx_mid) begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_tcnt  <= '0;
            rx_bitn  <= '0;
          end else if (tick) begin
            rx_tcnt <= rx_tcnt + 1'b1;
          end
        end
        default: begin
          if (tick) rx_tcnt <= rx_samp ? '0 : rx_tcnt + 1'b1;
          if (rx_samp) begin
            case (rx_state)
              S_DATA: begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                if (rx_bitn == 3'd7) rx_state <= parity_en ? S_PARITY : S_STOP;
                else                 rx_bitn  <= rx_bitn + 1'b1;
              end
              S_PARITY: begin
                rx_perr  <= (rx_s2 != (^rx_shift ^ parity_odd));
                rx_state <= S_STOP;
              end
              default: rx_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Host-visible status and flow flags
  assign status = {rx_overrun, frame_err, parity_err, tx_overflow,
                   (tx_state != S_IDLE) || !tx_empty, tx_full, tx_empty, rx_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rda <= 1'b0;
      tbr <= 1'b1;
    end else begin
      rda <= !rx_empty;
      tbr <= !tx_full;
    end
  end

  always_comb begin
    rd_data = '0;
    case (ioaddr)
      2'b00:   rd_data = rx_empty ? 8'h00 : rx_mem[rx_rptr];
      2'b01:   rd_data = status;
      2'b10:   rd_data = divisor[7:0];
      default: rd_data = divisor[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 'z;

endmodule

// File: tb/tb_spart_fifo.sv
// Scoreboarded bench for spart_fifo: host-side stimulus feeds expected queues,
// independent monitors decode txd frames and host data reads.
module tb_spart_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0, iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic       rda, tbr, txd, rxd;
  logic       host_oe = 1'b0;
  logic [7:0] host_drv = 8'h00;
  logic       loop = 1'b0, rxd_drv = 1'b1;

  assign databus = host_oe ? host_drv : 'z;
  assign rxd     = loop ? txd : rxd_drv;

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic par_en_m = 1'b0, par_odd_m = 1'b0, tx_mon_en = 1'b0;

  spart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'h028B), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; host_drv = d; host_oe = 1'b1;
    @(posedge clk);
    #1 iocs = 1'b0; host_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] d;
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!rda && w < 600) begin @(negedge clk); w++; end
      if (!rda) begin timeout("rda_wait"); return; end
      bus_read(2'b00, d);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic wait_txd_low(input int bound);
    int w = 0;
    while (txd && w < bound) begin @(negedge clk); w++; end
    if (txd) timeout("txd_start");
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic pb, input logic sb);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = b[k];
      repeat (16) @(negedge clk);
    end
    rxd_drv = pb;
    repeat (16) @(negedge clk);
    rxd_drv = sb;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Host data-read monitor: every strobed read of register 00 consumes one expected byte
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    #2;
    if (iocs && iorw && ioaddr == 2'b00) begin
      mon_exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      check("rx_data", databus, mon_exp);
    end
  end

  // Serial monitor: decodes txd at 16 clocks per bit (divisor 1)
  logic [7:0] tm_b, tm_exp;
  logic       tm_p;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n && txd == 1'b0) begin
        repeat (8) @(negedge clk);
        check("tx_start_bit", txd, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge clk);
          tm_b[k] = txd;
        end
        if (par_en_m) begin
          repeat (16) @(negedge clk);
          tm_p = txd;
        end
        repeat (16) @(negedge clk);
        check("tx_stop_bit", txd, 1'b1);
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_frame: got unexpected byte %0h, expected none", tm_b);
        end else begin
          tm_exp = tx_q.pop_front();
          check("tx_byte", tm_b, tm_exp);
          if (par_en_m) check("tx_parity", tm_p, ^tm_exp ^ par_odd_m);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] d, b, pat;
  logic       tr [200];
  logic       rdt[200];
  int         n, s, r, mism, mode;
  logic       e;

  initial begin
    pat = 8'hB4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_rda", rda, 1'b0);
    check("reset_tbr", tbr, 1'b1);
    bus_read(2'b01, d);
    check("reset_status", d, 8'h03);
    bus_read(2'b00, d);

    // Reset divisor: a data bit lasts 16 * 651 clocks
    bus_write(2'b00, 8'h01);
    wait_txd_low(20);
    n = 0;
    while (!txd && n < 11000) begin @(negedge clk); n++; end
    n = 0;
    while (txd && n < 12000) begin @(negedge clk); n++; end
    check("bit_time_reset_div", n, 16 * 651);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    tx_mon_en = 1'b1;
    loop = 1'b1;

    // Loopback of 0xB4 with exact waveform
    tx_q.push_back(pat); rx_q.push_back(pat);
    bus_write(2'b00, pat);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tr[i] = txd; rdt[i] = rda;
    end
    s = 0;
    while (s < 199 && tr[s]) s++;
    check("tx_start_latency", s, 1);
    mism = 0;
    for (int j = 0; j < 160; j++) begin
      if (j < 16) e = 1'b0;
      else if (j < 144) e = pat[(j / 16) - 1];
      else e = 1'b1;
      if (s + j < 200 && tr[s + j] !== e) mism++;
    end
    check("tx_waveform_mismatches", mism, 0);
    r = 0;
    while (r < 199 && !rdt[r]) r++;
    check("rda_rise_window", (r >= 140 && r <= 180), 1'b1);
    bus_read(2'b00, d);
    repeat (2) @(negedge clk);
    check("rda_fall_after_pop", rda, 1'b0);

    // Overflow: ten single-cycle writes into an empty FIFO with an idle transmitter
    for (int i = 0; i < 10; i++) begin
      b = 8'(i);
      bus_write(2'b00, b);
      if (i < DEPTH + 1) begin tx_q.push_back(b); rx_q.push_back(b); end
    end
    @(negedge clk);
    check("tbr_full", tbr, 1'b0);
    bus_read(2'b01, d);
    check("status_overflow", d, 8'h1D);
    read_bytes(DEPTH + 1);
    repeat (40) @(negedge clk);
    bus_read(2'b01, d);
    check("overflow_sticky", d, 8'h13);
    bus_write(2'b01, 8'h80);
    bus_read(2'b01, d);
    check("overflow_cleared", d, 8'h03);

    // Random loopback batches with random parity mode
    for (int bt = 0; bt < 3; bt++) begin
      mode = $urandom_range(0, 2);
      par_en_m = (mode != 0);
      par_odd_m = (mode == 2);
      bus_write(2'b01, {6'b0, par_odd_m, par_en_m});
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bus_write(2'b00, b);
        tx_q.push_back(b); rx_q.push_back(b);
      end
      read_bytes(n);
      repeat (40) @(negedge clk);
    end
    bus_write(2'b01, 8'h00);
    par_en_m = 1'b0; par_odd_m = 1'b0;

    // Overrun: DEPTH+1 frames arrive with no host reads
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      bus_write(2'b00, b);
      tx_q.push_back(b);
      if (i < DEPTH) rx_q.push_back(b);
    end
    repeat ((DEPTH + 1) * 160 + 100) @(negedge clk);
    check("overrun_rda", rda, 1'b1);
    bus_read(2'b01, d);
    check("status_overrun", d, 8'h82);
    read_bytes(DEPTH);
    bus_read(2'b00, d);
    bus_write(2'b01, 8'h80);
    bus_read(2'b01, d);
    check("overrun_cleared", d, 8'h03);

    // Bench-driven frames: parity error, framing error, glitch
    loop = 1'b0;
    bus_write(2'b01, 8'h81);
    par_en_m = 1'b1;
    rx_q.push_back(8'h55);
    drive_frame(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    bus_read(2'b01, d);
    check("status_parity_err", d, 8'h22);
    bus_read(2'b00, d);
    drive_frame(8'hA3, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    bus_read(2'b01, d);
    check("status_frame_err", d, 8'h63);
    check("frame_err_no_push", rda, 1'b0);
    bus_write(2'b01, 8'h81);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (60) @(negedge clk);
    bus_read(2'b01, d);
    check("glitch_status", d, 8'h03);
    check("glitch_rda", rda, 1'b0);

    // Reset in the middle of TX bit 3
    bus_write(2'b01, 8'h00);
    par_en_m = 1'b0;
    loop = 1'b1;
    tx_mon_en = 1'b0;
    bus_write(2'b00, 8'hC6);
    wait_txd_low(20);
    repeat (16 + 48 + 8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_rda", rda, 1'b0);
    check("abort_tbr", tbr, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'b01, d);
    check("post_abort_status", d, 8'h03);
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    tx_mon_en = 1'b1;
    b = 8'($urandom);
    tx_q.push_back(b); rx_q.push_back(b);
    bus_write(2'b00, b);
    read_bytes(1);
    repeat (60) @(negedge clk);

    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
